// File: rtl/pipe_debug_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline debug controller.
// State and command codes are fixed so the debug state output can be decoded externally.
package pipe_debug_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CMD_RUN     = 2'd0,
        CMD_STEP    = 2'd1,
        CMD_PAUSE   = 2'd2,
        CMD_CLR_CNT = 2'd3
    } cmd_e;

    localparam int NB_BITS_DEFAULT      = 32;
    localparam int DRAIN_CYCLES_DEFAULT = 4;

    // STEP and DRAIN are busy states; commands offered there are dropped, not queued.
    function automatic logic state_takes_cmd(state_e s);
        return (s == ST_IDLE) || (s == ST_RUN) || (s == ST_HALTED);
    endfunction

endpackage

// File: rtl/pipe_debug_ctrl_if.sv
// Debug command handshake and pipeline control bundle for pipe_debug_ctrl.
// A command transfers on a rising clock edge where i_cmd_valid and o_cmd_ready are both high.
interface pipe_debug_ctrl_if #(
    parameter int NB_BITS = 32
);
    logic               i_cmd_valid;
    logic [1:0]         i_cmd;
    logic               o_cmd_ready;
    logic               i_halt_instr;
    logic               i_load_use;
    logic               o_pipe_en;
    logic               o_pc_we;
    logic               o_if_id_we;
    logic               o_id_ex_flush;
    logic               o_done;
    logic [2:0]         o_state;
    logic [NB_BITS-1:0] o_cycle_cnt;

    modport slave (
        input  i_cmd_valid, i_cmd, i_halt_instr, i_load_use,
        output o_cmd_ready, o_pipe_en, o_pc_we, o_if_id_we, o_id_ex_flush,
        output o_done, o_state, o_cycle_cnt
    );

    modport master (
        output i_cmd_valid, i_cmd, i_halt_instr, i_load_use,
        input  o_cmd_ready, o_pipe_en, o_pc_we, o_if_id_we, o_id_ex_flush,
        input  o_done, o_state, o_cycle_cnt
    );
endinterface

// File: rtl/pipe_debug_ctrl_cycle_counter.sv
// pipe_cycle_counter: saturating up-counter of enabled pipeline cycles.
// A clear in the same cycle as an increment wins and leaves the count at zero.
module pipe_cycle_counter #(
    parameter int NB_BITS = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_inc,
    input  logic               i_clr,
    output logic [NB_BITS-1:0] o_cnt
);
    logic [NB_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + NB_BITS'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;
endmodule

// File: rtl/pipe_debug_ctrl.sv
// Run/step/halt debug controller for a 5-stage pipeline with load-use stall handling.
// Cycle counter present only when PIPE_DBG_CYCLE_CNT_EN is defined; otherwise tied to zero.
module pipe_debug_ctrl
    import pipe_debug_ctrl_pkg::*;
#(
    parameter int NB_BITS      = NB_BITS_DEFAULT,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
    input logic              i_clk,
    input logic              i_rst,
    pipe_debug_ctrl_if.slave bus
);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    state_e               state_q, state_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic                 done_q, done_d;
    cmd_e                 cmd;
    logic                 cmd_ready, cmd_acc;
    logic                 pipe_en, pc_we, if_id_we, id_ex_flush;

    assign cmd       = cmd_e'(bus.i_cmd);
    assign cmd_ready = state_takes_cmd(state_q);
    assign cmd_acc   = bus.i_cmd_valid && cmd_ready;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_acc && (cmd == CMD_RUN)) state_d = ST_RUN;
                else if (cmd_acc && (cmd == CMD_STEP)) state_d = ST_STEP;
            end
            // A halt reaching decode outranks a simultaneous PAUSE.
            ST_RUN: begin
                if (bus.i_halt_instr) state_d = ST_DRAIN;
                else if (cmd_acc && (cmd == CMD_PAUSE)) state_d = ST_IDLE;
            end
            ST_STEP:   state_d = bus.i_halt_instr ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: begin
                drain_d = drain_q - DRAIN_W'(1);
                if (drain_q <= DRAIN_W'(1)) state_d = ST_HALTED;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
        if ((state_d == ST_DRAIN) && (state_q != ST_DRAIN)) begin
            drain_d = DRAIN_W'(DRAIN_CYCLES);
        end
        done_d = (state_d == ST_HALTED) && (state_q != ST_HALTED);
    end

    always_comb begin
        pipe_en     = 1'b0;
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b0;
        case (state_q)
            ST_RUN, ST_STEP: begin
                // Load-use: hold PC and IF/ID, bubble ID/EX, let the back end advance.
                pipe_en     = 1'b1;
                pc_we       = !bus.i_load_use;
                if_id_we    = !bus.i_load_use;
                id_ex_flush = bus.i_load_use;
            end
            ST_DRAIN: pipe_en = 1'b1;
            default: ;
        endcase
    end

    assign bus.o_cmd_ready   = cmd_ready;
    assign bus.o_pipe_en     = pipe_en;
    assign bus.o_pc_we       = pc_we;
    assign bus.o_if_id_we    = if_id_we;
    assign bus.o_id_ex_flush = id_ex_flush;
    assign bus.o_done        = done_q;
    assign bus.o_state       = state_q;

`ifdef PIPE_DBG_CYCLE_CNT_EN
    pipe_cycle_counter #(.NB_BITS(NB_BITS)) u_cycle_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (pipe_en),
        .i_clr (cmd_acc && (cmd == CMD_CLR_CNT)),
        .o_cnt (bus.o_cycle_cnt)
    );
`else
    assign bus.o_cycle_cnt = '0;
`endif
endmodule
